lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 64, range 1-255: memory cycles allowed per transaction before abort.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_mem_rden  in  1  load instruction present (decoded ld, wb_sel=2'b10).
REQ-005 i_mem_wren  in  1  store instruction present (mem_wren from control).
REQ-006 i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_addr  in  32  byte address (ALU result).
REQ-008 i_st_data  in  32  rs2 data for stores.
REQ-009 o_ld_data  out  32  extended load result to writeback.
REQ-010 o_stall  out  1  core must hold PC/instruction while high.
REQ-011 o_err  out  1  one-cycle pulse: misaligned/illegal access or timeout.
REQ-012 o_dmem_req, o_dmem_we  out  1 each  memory request / write qualifier.
REQ-013 o_dmem_addr  out  32  word address, {i_addr[31:2],2'b00}.
REQ-014 o_dmem_be  out  4  byte enables; o_dmem_wdata  out  32  lane-aligned store data.
REQ-015 i_dmem_gnt  in  1  request accepted; i_dmem_rvalid  in  1  read data valid; i_dmem_rdata  in  32.

Function
REQ-016 FSM states IDLE, REQ, WAIT_R, DONE; reset state IDLE.
REQ-017 IDLE, (rden|wren) and legal: latch addr, be, wdata, funct3, offset, we; go REQ; o_stall=1 combinationally that cycle.
REQ-018 rden and wren both high: treated as store.
REQ-019 Illegal: H/HU with addr[0]=1; W with addr[1:0]!=0; load funct3 011/110/111; store funct3 >=011. Response: o_err pulse next cycle, no memory request, o_stall=0, state to DONE.
REQ-020 REQ: o_dmem_req=1 with addr/be/we/wdata held stable until i_dmem_gnt; on gnt store -> DONE, load -> WAIT_R.
REQ-021 i_dmem_rvalid accepted only in WAIT_R (earliest cycle after gnt); ignored in all other states.
REQ-022 WAIT_R on rvalid: register extracted data into o_ld_data, go DONE.
REQ-023 DONE: o_stall=0 for exactly one cycle, o_ld_data valid; inputs ignored; next state IDLE.
REQ-024 o_stall=1 in REQ and WAIT_R unconditionally.
REQ-025 Store be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. wdata: SB {4{st[7:0]}}, SH {2{st[15:0]}}, SW st.
REQ-026 Load extract: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 8-bit cycle counter cleared on entry to REQ, increments each REQ/WAIT_R cycle; reaching TIMEOUT: o_err pulse, o_ld_data=0, o_dmem_req dropped, go DONE.
REQ-028 o_ld_data retains last value except on load completion or timeout.
REQ-029 o_dmem_req=0 and o_dmem_we=0 in IDLE, WAIT_R, DONE.

Reset
REQ-030 i_rst_n low asynchronously forces IDLE, counter 0, o_ld_data=0, o_err=0, o_dmem_req=0, o_dmem_we=0, o_dmem_be=0, o_dmem_wdata=0, o_dmem_addr=0.
REQ-031 Reset mid-transaction abandons it; late gnt/rvalid after reset release ignored in IDLE.
REQ-032 Release synchronous to i_clk; first access accepted on first rising edge with i_rst_n high.

Verification
REQ-033 LB addr 0x103, rdata 0x80FF_FFFF, gnt 1 cycle after req, rvalid 2 later -> o_ld_data 0xFFFF_FF80, stall high 4 cycles then low 1.
REQ-034 SH addr 0x202, st_data 0x1234_ABCD, gnt immediate -> dmem_addr 0x200, be 4'b1100, wdata 0xABCD_ABCD, we=1; next DONE.
REQ-035 LW addr 0x006 -> o_err pulse, no o_dmem_req, o_stall stays 0.
REQ-036 TIMEOUT=4, load, gnt never asserted -> o_err after 4 REQ cycles, o_ld_data 0, return IDLE.
REQ-037 Reset in WAIT_R, rvalid asserted after release -> outputs at reset values, o_ld_data unchanged at 0.
REQ-038 LHU addr 0x012, rdata 0xF00D_1234 -> o_ld_data 0x0000_F00D.

Source files
------------

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the core pipeline and a data memory port.
//
// A load or store is accepted while the FSM is in IDLE. The address, byte
// enables and store data are captured and the request is presented to memory.
// Load data is lane-extracted and sign- or zero-extended into o_ld_data.
// Misaligned or illegal accesses, and transactions that exceed TIMEOUT
// memory cycles, produce a one-cycle o_err pulse.
//
// Ports
//   i_clk, i_rst_n         clock; asynchronous active-low reset
//   i_mem_rden/i_mem_wren  load / store present (both high = store)
//   i_funct3               size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr, i_st_data      byte address, store source data
//   o_ld_data              extended load result
//   o_stall                hold the pipeline while high
//   o_err                  one-cycle error pulse
//   o_dmem_*               memory request channel (word address, lane enables)
//   i_dmem_gnt/rvalid/rdata memory grant and read response
// ---------------------------------------------------------------------------
module lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_rden,
  input  logic        i_mem_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic        we_reg;
  logic        err_reg;
  logic [31:0] ld_data_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;

  logic        access;
  logic        legal;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_extract;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign access = i_mem_rden | i_mem_wren;

  // Legality check; a store wins when both enables are high.
  always_comb begin
    legal = 1'b0;
    case (i_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~i_addr[0];
      3'b010:  legal = (i_addr[1:0] == 2'b00);
      3'b100:  legal = ~i_mem_wren;
      3'b101:  legal = ~i_mem_wren & ~i_addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state_reg == IDLE) && access && legal;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = i_st_data;
    case (i_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << i_addr[1:0];
        wdata_next = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << i_addr[1:0];
        wdata_next = {2{i_st_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = i_st_data;
      end
    endcase
  end

  // Lane extraction uses the offset captured at accept time.
  always_comb begin
    ld_byte    = i_dmem_rdata[7:0];
    ld_half    = offset_reg[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    ld_extract = i_dmem_rdata;
    case (offset_reg)
      2'b00:   ld_byte = i_dmem_rdata[7:0];
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    case (funct3_reg)
      3'b000:  ld_extract = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_extract = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_extract = {24'd0, ld_byte};
      3'b101:  ld_extract = {16'd0, ld_half};
      default: ld_extract = i_dmem_rdata;
    endcase
  end

  // The counter is cleared on entry to REQ, so this fires on the
  // TIMEOUT-th memory cycle of the transaction.
  assign timeout_hit = ((cnt_reg + 8'd1) == TMO);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state; a grant or read response wins over a same-cycle timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (access) state_next = legal ? REQ : DONE;
      end
      REQ: begin
        if (i_dmem_gnt)       state_next = we_reg ? DONE : WAIT_R;
        else if (timeout_hit) state_next = DONE;
      end
      WAIT_R: begin
        if (i_dmem_rvalid || timeout_hit) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_stall    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    case (state_reg)
      IDLE:   o_stall = access & legal;
      REQ: begin
        o_stall    = 1'b1;
        o_dmem_req = 1'b1;
        o_dmem_we  = we_reg;
      end
      WAIT_R: o_stall = 1'b1;
      default: o_stall = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg     <= 8'd0;
      funct3_reg  <= 3'd0;
      offset_reg  <= 2'd0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      ld_data_reg <= 32'd0;
      addr_reg    <= 32'd0;
      be_reg      <= 4'd0;
      wdata_reg   <= 32'd0;
    end else begin
      err_reg <= 1'b0;
      if (accept) begin
        cnt_reg    <= 8'd0;
        funct3_reg <= i_funct3;
        offset_reg <= i_addr[1:0];
        we_reg     <= i_mem_wren;
        addr_reg   <= {i_addr[31:2], 2'b00};
        be_reg     <= be_next;
        wdata_reg  <= wdata_next;
      end
      if (state_reg == IDLE && access && !legal) err_reg <= 1'b1;
      if (state_reg == REQ || state_reg == WAIT_R) cnt_reg <= cnt_reg + 8'd1;
      if (state_reg == WAIT_R && i_dmem_rvalid) begin
        ld_data_reg <= ld_extract;
      end else if ((state_reg == REQ && !i_dmem_gnt && timeout_hit) ||
                   (state_reg == WAIT_R && timeout_hit)) begin
        err_reg     <= 1'b1;
        ld_data_reg <= 32'd0;
      end
    end
  end

  assign o_err        = err_reg;
  assign o_ld_data    = ld_data_reg;
  assign o_dmem_addr  = addr_reg;
  assign o_dmem_be    = be_reg;
  assign o_dmem_wdata = wdata_reg;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed testbench for lsu (TIMEOUT=4). Each task drives one
// scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        mem_rden, mem_wren;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic [31:0] ld_data;
  logic        stall, err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  lsu #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mem_rden   (mem_rden),
    .i_mem_wren   (mem_wren),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_st_data    (st_data),
    .o_ld_data    (ld_data),
    .o_stall      (stall),
    .o_err        (err),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_be    (dmem_be),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_gnt   (dmem_gnt),
    .i_dmem_rvalid(dmem_rvalid),
    .i_dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    funct3      = 3'd0;
    addr        = 32'd0;
    st_data     = 32'd0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet();
    step(); step();
    #1;
    checks++;
    if ({stall, err, dmem_req, dmem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {stall, err, dmem_req, dmem_we});
    end
    checks++;
    if ({ld_data, dmem_addr, dmem_wdata, dmem_be} !== 100'd0) begin
      errors++; $display("FAIL reset_data got ld=%h a=%h wd=%h be=%b want all zero",
                         ld_data, dmem_addr, dmem_wdata, dmem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  // Reset asserted while waiting for read data; late rvalid must be ignored.
  task automatic test_reset_mid();
    step();
    mem_rden = 1'b1; funct3 = 3'b010; addr = 32'h0000_0020;
    step();
    quiet(); dmem_gnt = 1'b1;
    step();
    quiet();
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL mid_wait_stall got=%b want=1", stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, err, dmem_req, dmem_we, dmem_be} !== 8'd0 || dmem_addr !== 32'd0 ||
        dmem_wdata !== 32'd0 || ld_data !== 32'd0) begin
      errors++; $display("FAIL mid_async_reset got st=%b e=%b rq=%b we=%b be=%b a=%h ld=%h want zeros",
                         stall, err, dmem_req, dmem_we, dmem_be, dmem_addr, ld_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL mid_late_rvalid_stall got=%b want=0", stall);
    end
    step();
    quiet();
    #1;
    checks++;
    if (ld_data !== 32'd0 || err !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL mid_after ld=%h err=%b stall=%b want 0/0/0", ld_data, err, stall);
    end
    $display("reset_mid: ld_data=%h", ld_data);
  endtask

  // LB 0x103, grant in first REQ cycle, rvalid two cycles after grant.
  task automatic test_lb();
    int nstall;
    nstall = 0;
    step();
    mem_rden = 1'b1; funct3 = 3'b000; addr = 32'h0000_0103;
    #1; nstall += int'(stall);
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL lb_accept stall=%b req=%b want 1/0", stall, dmem_req);
    end
    step();
    quiet(); dmem_gnt = 1'b1;
    #1; nstall += int'(stall);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b1000) begin
      errors++; $display("FAIL lb_req req=%b we=%b a=%h be=%b want 1/0/100/1000",
                         dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    step();
    quiet(); dmem_rvalid = 1'b0;
    #1; nstall += int'(stall);
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL lb_wait_req got=%b want=0", dmem_req);
    end
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    #1; nstall += int'(stall);
    step();
    quiet();
    #1;
    checks++;
    if (stall !== 1'b0 || ld_data !== 32'hFFFF_FF80 || err !== 1'b0) begin
      errors++; $display("FAIL lb_done stall=%b ld=%h err=%b want 0/ffffff80/0", stall, ld_data, err);
    end
    checks++;
    if (nstall !== 4) begin
      errors++; $display("FAIL lb_stall_cycles got=%0d want=4", nstall);
    end
    $display("lb: addr=103 ld_data=%h stall_cycles=%0d", ld_data, nstall);
  endtask

  // Generic load with immediate grant and rvalid in the first WAIT_R cycle.
  task automatic test_load(input string name, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp_ld);
    step();
    mem_rden = 1'b1; funct3 = f3; addr = a;
    step();
    quiet(); dmem_gnt = 1'b1;
    step();
    quiet(); dmem_rvalid = 1'b1; dmem_rdata = rd;
    step();
    quiet();
    #1;
    checks++;
    if (ld_data !== exp_ld || stall !== 1'b0) begin
      errors++; $display("FAIL %s ld=%h stall=%b want %h/0", name, ld_data, stall, exp_ld);
    end
    $display("%s: addr=%h rdata=%h ld_data=%h", name, a, rd, ld_data);
  endtask

  task automatic test_store(input string name, input logic rd_too, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] exp_a, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
    step();
    mem_wren = 1'b1; mem_rden = rd_too; funct3 = f3; addr = a; st_data = sd;
    step();
    quiet(); dmem_gnt = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== exp_a ||
        dmem_be !== exp_be || dmem_wdata !== exp_wd) begin
      errors++; $display("FAIL %s req=%b we=%b a=%h be=%b wd=%h want 1/1/%h/%b/%h", name,
                         dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exp_a, exp_be, exp_wd);
    end
    step();
    quiet();
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL %s_done stall=%b req=%b we=%b err=%b want 0000", name,
                         stall, dmem_req, dmem_we, err);
    end
    $display("%s: addr=%h be=%b wdata=%h", name, a, dmem_be, dmem_wdata);
  endtask

  task automatic test_illegal(input string name, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a);
    step();
    mem_rden = ~wr; mem_wren = wr; funct3 = f3; addr = a;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL %s_accept stall=%b req=%b err=%b want 0/0/0", name, stall, dmem_req, err);
    end
    step();
    quiet();
    #1;
    checks++;
    if (err !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL %s_err err=%b req=%b stall=%b want 1/0/0", name, err, dmem_req, stall);
    end
    step();
    #1;
    checks++;
    if (err !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL %s_pulse err=%b req=%b want 0/0", name, err, dmem_req);
    end
    $display("%s: funct3=%b addr=%h error flagged", name, f3, a);
  endtask

  // Load never granted with TIMEOUT=4: exactly four REQ cycles, then abort.
  task automatic test_timeout();
    int nreq;
    nreq = 0;
    step();
    mem_rden = 1'b1; funct3 = 3'b010; addr = 32'h0000_0010;
    for (int i = 0; i < 12; i++) begin
      step();
      quiet();
      #1;
      if (dmem_req) nreq++;
      else break;
    end
    checks++;
    if (nreq !== 4) begin
      errors++; $display("FAIL timeout_req_cycles got=%0d want=4", nreq);
    end
    checks++;
    if (err !== 1'b1 || ld_data !== 32'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_abort err=%b ld=%h stall=%b want 1/0/0", err, ld_data, stall);
    end
    step();
    mem_rden = 1'b1; funct3 = 3'b010; addr = 32'h0000_0010;
    #1;
    checks++;
    if (err !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL timeout_idle err=%b stall=%b want 0/1", err, stall);
    end
    step();
    quiet(); dmem_gnt = 1'b1;
    step();
    quiet(); dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    step();
    quiet();
    $display("timeout: req_cycles=%0d", nreq);
  endtask

  initial begin
    quiet();
    test_reset();
    test_reset_mid();
    test_lb();
    test_timeout();
    test_load("lhu", 3'b101, 32'h0000_0012, 32'hF00D_1234, 32'h0000_F00D);
    test_load("lh",  3'b001, 32'h0000_0012, 32'hF00D_1234, 32'hFFFF_F00D);
    test_load("lbu", 3'b100, 32'h0000_0021, 32'h1234_A5C3, 32'h0000_00A5);
    test_load("lw",  3'b010, 32'h0000_0040, 32'hCAFE_0001, 32'hCAFE_0001);
    test_store("sh", 1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD,
               32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    test_store("sb", 1'b0, 3'b000, 32'h0000_0301, 32'h0000_00EF,
               32'h0000_0300, 4'b0010, 32'hEFEF_EFEF);
    test_store("sw_rdwr", 1'b1, 3'b010, 32'h0000_0408, 32'h89AB_CDEF,
               32'h0000_0408, 4'b1111, 32'h89AB_CDEF);
    test_illegal("lw_misaligned", 1'b0, 3'b010, 32'h0000_0006);
    test_illegal("lh_odd",        1'b0, 3'b001, 32'h0000_0011);
    test_illegal("ld_f3_011",     1'b0, 3'b011, 32'h0000_0000);
    test_illegal("sbu_store",     1'b1, 3'b100, 32'h0000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
